// File: rtl/cr16_pkg.sv
// Shared definitions for the CompactRISC16 control path: states, instruction
// encodings, condition codes, flag positions and ALU function codes.
package cr16_pkg;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DECODE  = 2'd1,
      ST_EXECUTE = 2'd2,
      ST_LOAD_WB = 2'd3
   } state_e;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ANDI  = 4'b0001;
   localparam logic [3:0] OP_ORI   = 4'b0010;
   localparam logic [3:0] OP_XORI  = 4'b0011;
   localparam logic [3:0] OP_MEM   = 4'b0100;
   localparam logic [3:0] OP_ADDI  = 4'b0101;
   localparam logic [3:0] OP_SUBI  = 4'b1001;
   localparam logic [3:0] OP_CMPI  = 4'b1011;
   localparam logic [3:0] OP_BCOND = 4'b1100;
   localparam logic [3:0] OP_MOVI  = 4'b1101;
   localparam logic [3:0] OP_LUI   = 4'b1111;

   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JCOND = 4'b1100;

   // ALU function codes share the R-type opext / immediate op encoding,
   // so the decoder can forward the instruction field unchanged.
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_ADD = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b1001;
   localparam logic [3:0] ALU_CMP = 4'b1011;
   localparam logic [3:0] ALU_MOV = 4'b1101;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_HI = 4'b0100;
   localparam logic [3:0] COND_LS = 4'b0101;
   localparam logic [3:0] COND_GT = 4'b0110;
   localparam logic [3:0] COND_LE = 4'b0111;
   localparam logic [3:0] COND_FS = 4'b1000;
   localparam logic [3:0] COND_FC = 4'b1001;
   localparam logic [3:0] COND_LO = 4'b1010;
   localparam logic [3:0] COND_HS = 4'b1011;
   localparam logic [3:0] COND_LT = 4'b1100;
   localparam logic [3:0] COND_GE = 4'b1101;
   localparam logic [3:0] COND_UC = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_C = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 4;

   function automatic logic is_alu_fn(input logic [3:0] fn);
      return fn inside {ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_CMP, ALU_MOV};
   endfunction

   function automatic logic is_arith_fn(input logic [3:0] fn);
      return fn inside {ALU_ADD, ALU_SUB, ALU_CMP};
   endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// Branch/jump condition evaluation against the latched status flags.
module cr16_cond_eval
   import cr16_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [4:0] flags,
   output logic       taken
);

   logic c_f, l_f, f_f, z_f, n_f;

   assign c_f = flags[FLAG_C];
   assign l_f = flags[FLAG_L];
   assign f_f = flags[FLAG_F];
   assign z_f = flags[FLAG_Z];
   assign n_f = flags[FLAG_N];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken = z_f;
         COND_NE: taken = !z_f;
         COND_CS: taken = c_f;
         COND_CC: taken = !c_f;
         COND_HI: taken = l_f;
         COND_LS: taken = !l_f;
         COND_GT: taken = n_f;
         COND_LE: taken = !n_f;
         COND_FS: taken = f_f;
         COND_FC: taken = !f_f;
         COND_LO: taken = !l_f && !z_f;
         COND_HS: taken = l_f || z_f;
         COND_LT: taken = !n_f && !z_f;
         COND_GE: taken = n_f || z_f;
         COND_UC: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle fetch/decode/execute controller for the CompactRISC16 core.
// state      | meaning
// ST_FETCH   | present PC on the memory address bus
// ST_DECODE  | capture memory read data into IR
// ST_EXECUTE | drive datapath controls, update PC/flags, start load
// ST_LOAD_WB | write load data into Rdest
module control_fsm
   import cr16_pkg::*;
#(
   parameter logic [15:0] P_RESET_PC = 16'h0000
) (
   input  logic        I_CLK,
   input  logic        I_NRESET,
   input  logic        I_ENABLE,
   input  logic [15:0] I_MEM_RDATA,
   input  logic [15:0] I_A,
   input  logic [15:0] I_B,
   input  logic [4:0]  I_STATUS_FLAGS,
   output logic [15:0] O_MEM_ADDR,
   output logic        O_MEM_WE,
   output logic [15:0] O_MEM_WDATA,
   output logic [15:0] O_REG_WRITE_ENABLE,
   output logic [3:0]  O_REG_A_SELECT,
   output logic [3:0]  O_REG_B_SELECT,
   output logic [15:0] O_IMMEDIATE,
   output logic        O_IMMEDIATE_SELECT,
   output logic [3:0]  O_OPCODE,
   output logic        O_REGFILE_DATA_SELECT,
   output logic [15:0] O_PC
);

   state_e      state_q, state_d, nxt_state;
   logic [15:0] pc_q, pc_d, nxt_pc;
   logic [15:0] ir_q, ir_d, nxt_ir;
   logic [4:0]  flags_q, flags_d;

   logic [3:0]  op, rdest, opext, rsrc;
   logic [7:0]  imm8;
   logic [15:0] pc_inc, pc_branch;
   logic        cond_taken;
   logic        wr_req, we_req, latch_flags;

   assign op    = ir_q[15:12];
   assign rdest = ir_q[11:8];
   assign opext = ir_q[7:4];
   assign rsrc  = ir_q[3:0];
   assign imm8  = ir_q[7:0];

   assign pc_inc    = pc_q + 16'd1;
   assign pc_branch = pc_q + {{8{imm8[7]}}, imm8};
   assign O_PC      = pc_q;

   cr16_cond_eval u_cond_eval (
      .cond  (rdest),
      .flags (flags_q),
      .taken (cond_taken)
   );

   always_comb begin
      nxt_state             = state_q;
      nxt_pc                = pc_q;
      nxt_ir                = ir_q;
      wr_req                = 1'b0;
      we_req                = 1'b0;
      latch_flags           = 1'b0;
      O_MEM_ADDR            = pc_q;
      O_MEM_WDATA           = 16'h0000;
      O_REG_A_SELECT        = 4'h0;
      O_REG_B_SELECT        = 4'h0;
      O_IMMEDIATE           = 16'h0000;
      O_IMMEDIATE_SELECT    = 1'b0;
      O_OPCODE              = 4'h0;
      O_REGFILE_DATA_SELECT = 1'b0;

      unique case (state_q)
         ST_FETCH: nxt_state = ST_DECODE;
         ST_DECODE: begin
            nxt_ir    = I_MEM_RDATA;
            nxt_state = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            nxt_state = ST_FETCH;
            nxt_pc    = pc_inc;
            case (op)
               OP_RTYPE: begin
                  if (is_alu_fn(opext)) begin
                     O_REG_A_SELECT = rsrc;
                     O_REG_B_SELECT = rdest;
                     O_OPCODE       = opext;
                     wr_req         = (opext != ALU_CMP);
                     latch_flags    = is_arith_fn(opext);
                  end
               end
               OP_ANDI, OP_ORI, OP_XORI, OP_MOVI: begin
                  O_IMMEDIATE_SELECT = 1'b1;
                  O_REG_B_SELECT     = rdest;
                  O_IMMEDIATE        = {8'h00, imm8};
                  O_OPCODE           = op;
                  wr_req             = 1'b1;
               end
               OP_ADDI, OP_SUBI, OP_CMPI: begin
                  O_IMMEDIATE_SELECT = 1'b1;
                  O_REG_B_SELECT     = rdest;
                  O_IMMEDIATE        = {{8{imm8[7]}}, imm8};
                  O_OPCODE           = op;
                  wr_req             = (op != OP_CMPI);
                  latch_flags        = 1'b1;
               end
               OP_LUI: begin
                  O_IMMEDIATE_SELECT = 1'b1;
                  O_REG_B_SELECT     = rdest;
                  O_IMMEDIATE        = {imm8, 8'h00};
                  O_OPCODE           = ALU_MOV;
                  wr_req             = 1'b1;
               end
               OP_MEM: begin
                  case (opext)
                     EXT_LOAD: begin
                        O_REG_B_SELECT = rsrc;
                        O_MEM_ADDR     = I_B;
                        nxt_state      = ST_LOAD_WB;
                        nxt_pc         = pc_q;
                     end
                     EXT_STOR: begin
                        O_REG_A_SELECT = rdest;
                        O_REG_B_SELECT = rsrc;
                        O_MEM_ADDR     = I_B;
                        O_MEM_WDATA    = I_A;
                        we_req         = 1'b1;
                     end
                     EXT_JCOND: begin
                        O_REG_B_SELECT = rsrc;
                        if (cond_taken) nxt_pc = I_B;
                     end
                     default: ;
                  endcase
               end
               OP_BCOND: begin
                  if (cond_taken) nxt_pc = pc_branch;
               end
               default: ;
            endcase
         end
         ST_LOAD_WB: begin
            // Keep the load address stable so a stall here re-reads the same word.
            O_REG_B_SELECT        = rsrc;
            O_MEM_ADDR            = I_B;
            O_REGFILE_DATA_SELECT = 1'b1;
            wr_req                = 1'b1;
            nxt_state             = ST_FETCH;
            nxt_pc                = pc_inc;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      flags_d = flags_q;
      if (I_ENABLE) begin
         state_d = nxt_state;
         pc_d    = nxt_pc;
         ir_d    = nxt_ir;
         if (latch_flags) flags_d = I_STATUS_FLAGS;
      end
   end

   assign O_REG_WRITE_ENABLE = (wr_req && I_ENABLE) ? (16'h0001 << rdest) : 16'h0000;
   assign O_MEM_WE           = we_req && I_ENABLE;

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         state_q <= ST_FETCH;
         pc_q    <= P_RESET_PC;
         ir_q    <= 16'h0000;
         flags_q <= 5'h00;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: instruction-level reference model,
// directed scenarios, random instruction streams with random stalls.
module tb_control_fsm;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic        enable = 1'b1;
   logic [15:0] mem_rdata = 16'h0000;
   logic [15:0] i_a, i_b;
   logic [4:0]  status = 5'h00;
   logic [15:0] mem_addr, mem_wdata, wen, imm, pc;
   logic        mem_we, imm_sel, dsel;
   logic [3:0]  a_sel, b_sel, opcode;

   bit   [15:0] regs [16];
   bit   [15:0] mem [65536];
   logic [15:0] pc_m;
   logic [4:0]  flags_m;
   int          n_checks = 0;
   int          n_errors = 0;

   localparam logic [3:0] MOV_CODE = 4'b1101;

   always #5 clk = ~clk;

   assign i_a = regs[a_sel];
   assign i_b = regs[b_sel];
   always @(posedge clk) mem_rdata <= mem[mem_addr];

   control_fsm #(.P_RESET_PC(16'h0000)) dut (
      .I_CLK                 (clk),
      .I_NRESET              (nreset),
      .I_ENABLE              (enable),
      .I_MEM_RDATA           (mem_rdata),
      .I_A                   (i_a),
      .I_B                   (i_b),
      .I_STATUS_FLAGS        (status),
      .O_MEM_ADDR            (mem_addr),
      .O_MEM_WE              (mem_we),
      .O_MEM_WDATA           (mem_wdata),
      .O_REG_WRITE_ENABLE    (wen),
      .O_REG_A_SELECT        (a_sel),
      .O_REG_B_SELECT        (b_sel),
      .O_IMMEDIATE           (imm),
      .O_IMMEDIATE_SELECT    (imm_sel),
      .O_OPCODE              (opcode),
      .O_REGFILE_DATA_SELECT (dsel),
      .O_PC                  (pc)
   );

   typedef struct {
      int          cycles;
      bit          wr;
      logic [15:0] wr_onehot;
      bit          dsel;
      bit          chk_a, chk_b;
      logic [3:0]  a_sel, b_sel;
      bit          chk_op;
      logic [3:0]  alu;
      bit          imm_sel;
      logic [15:0] imm;
      bit          chk_addr;
      logic [15:0] addr;
      bit          st;
      logic [15:0] st_data;
      logic [15:0] next_pc;
      bit          latch;
   } exp_t;

   function automatic bit cond_true(input logic [3:0] c, input logic [4:0] f);
      bit cf = f[0];
      bit lf = f[1];
      bit ff = f[2];
      bit zf = f[3];
      bit nf = f[4];
      bit tbl [16];
      tbl = '{zf, !zf, cf, !cf, lf, !lf, nf, !nf, ff, !ff,
              !lf && !zf, lf || zf, !nf && !zf, nf || zf, 1'b1, 1'b0};
      return tbl[c];
   endfunction

   // What one instruction should do, from the instruction-set rules.
   function automatic exp_t predict(input logic [15:0] ir, input logic [15:0] pcv,
                                    input logic [4:0] fl);
      exp_t e;
      logic [3:0] op = ir[15:12];
      logic [3:0] rd = ir[11:8];
      logic [3:0] ox = ir[7:4];
      logic [3:0] rs = ir[3:0];
      logic [15:0] sext = {{8{ir[7]}}, ir[7:0]};
      e = '{default: 0};
      e.cycles    = 3;
      e.next_pc   = pcv + 16'd1;
      e.wr_onehot = 16'h0000;
      e.wr_onehot[rd] = 1'b1;
      if (op == 4'h0 && (ox inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD})) begin
         e.chk_a = 1; e.a_sel = rs; e.chk_b = 1; e.b_sel = rd;
         e.chk_op = 1; e.alu = ox;
         e.wr = (ox != 4'hB);
         e.latch = (ox inside {4'h5, 4'h9, 4'hB});
      end else if (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF}) begin
         e.imm_sel = 1; e.chk_b = 1; e.b_sel = rd; e.chk_op = 1;
         e.alu = (op == 4'hF) ? MOV_CODE : op;
         if (op inside {4'h5, 4'h9, 4'hB}) e.imm = sext;
         else if (op == 4'hF) e.imm = {ir[7:0], 8'h00};
         else e.imm = {8'h00, ir[7:0]};
         e.wr = (op != 4'hB);
         e.latch = (op inside {4'h5, 4'h9, 4'hB});
      end else if (op == 4'h4 && ox == 4'h0) begin
         e.cycles = 4; e.wr = 1; e.dsel = 1;
         e.chk_b = 1; e.b_sel = rs; e.chk_addr = 1; e.addr = regs[rs];
      end else if (op == 4'h4 && ox == 4'h4) begin
         e.st = 1; e.chk_addr = 1; e.addr = regs[rs]; e.st_data = regs[rd];
      end else if (op == 4'h4 && ox == 4'hC) begin
         if (cond_true(rd, fl)) e.next_pc = regs[rs];
      end else if (op == 4'hC) begin
         if (cond_true(rd, fl)) e.next_pc = pcv + sext;
      end
      return e;
   endfunction

   // Runs one instruction from FETCH; entered and left just after a falling edge.
   task automatic exec_one(input logic [15:0] ir, input logic [4:0] stat,
                           input int stall_at, input int stall_len);
      exp_t e;
      int wen_cnt = 0, wen_cyc = -1, st_cnt = 0, st_cyc = -1, stall_bad = 0;
      logic [15:0] wen_val = 0, st_addr = 0, st_data = 0, x_imm = 0, x_addr = 0;
      logic x_imm_sel = 0, x_dsel = 0;
      logic [3:0] x_op = 0, x_a = 0, x_b = 0;
      e = predict(ir, pc_m, flags_m);
      mem[pc_m] = ir;
      status = stat;
      for (int c = 0; c < e.cycles; c++) begin
         if (c == stall_at) begin
            for (int k = 0; k < stall_len; k++) begin
               enable = 1'b0;
               #1;
               if (wen !== 16'h0 || mem_we !== 1'b0 || pc !== pc_m) stall_bad++;
               @(negedge clk);
            end
         end
         enable = 1'b1;
         #1;
         if (wen !== 16'h0) begin
            wen_cnt++; wen_cyc = c; wen_val = wen; x_dsel = dsel;
         end
         if (mem_we !== 1'b0) begin
            st_cnt++; st_cyc = c; st_addr = mem_addr; st_data = mem_wdata;
         end
         if (c == 2) begin
            x_imm_sel = imm_sel; x_imm = imm; x_op = opcode;
            x_a = a_sel; x_b = b_sel; x_addr = mem_addr;
         end
         @(negedge clk);
      end
      if (e.latch) flags_m = stat;

      n_checks++;
      if (wen_cnt != (e.wr ? 1 : 0) ||
          (e.wr && (wen_val !== e.wr_onehot || wen_cyc != e.cycles - 1 || x_dsel !== e.dsel))) begin
         n_errors++;
         $display("FAIL regwrite ir=%h: got cnt=%0d cyc=%0d we=%h dsel=%b, expected cnt=%0d cyc=%0d we=%h dsel=%b",
                  ir, wen_cnt, wen_cyc, wen_val, x_dsel, e.wr ? 1 : 0, e.cycles - 1, e.wr_onehot, e.dsel);
      end
      n_checks++;
      if (st_cnt != (e.st ? 1 : 0) ||
          (e.st && (st_cyc != 2 || st_addr !== e.addr || st_data !== e.st_data))) begin
         n_errors++;
         $display("FAIL store ir=%h: got cnt=%0d cyc=%0d addr=%h data=%h, expected cnt=%0d addr=%h data=%h",
                  ir, st_cnt, st_cyc, st_addr, st_data, e.st ? 1 : 0, e.addr, e.st_data);
      end
      n_checks++;
      if (x_imm_sel !== e.imm_sel || (e.imm_sel && x_imm !== e.imm) ||
          (e.chk_op && x_op !== e.alu)) begin
         n_errors++;
         $display("FAIL alu_ctrl ir=%h: got isel=%b imm=%h op=%h, expected isel=%b imm=%h op=%h",
                  ir, x_imm_sel, x_imm, x_op, e.imm_sel, e.imm, e.alu);
      end
      n_checks++;
      if ((e.chk_a && x_a !== e.a_sel) || (e.chk_b && x_b !== e.b_sel) ||
          (e.chk_addr && x_addr !== e.addr)) begin
         n_errors++;
         $display("FAIL operand ir=%h: got a=%h b=%h addr=%h, expected a=%h b=%h addr=%h",
                  ir, x_a, x_b, x_addr, e.a_sel, e.b_sel, e.addr);
      end
      n_checks++;
      if (pc !== e.next_pc || mem_addr !== e.next_pc) begin
         n_errors++;
         $display("FAIL next_pc ir=%h: got pc=%h fetch=%h, expected %h", ir, pc, mem_addr, e.next_pc);
      end
      if (stall_len > 0) begin
         n_checks++;
         if (stall_bad != 0) begin
            n_errors++;
            $display("FAIL stall_hold ir=%h: got %0d violations, expected 0", ir, stall_bad);
         end
      end
      pc_m = e.next_pc;
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      enable = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (mem_addr !== 16'h0000 || pc !== 16'h0000) begin
         n_errors++;
         $display("FAIL reset_pc: got addr=%h pc=%h, expected 0000", mem_addr, pc);
      end
      n_checks++;
      if ({wen, mem_we, mem_wdata, imm, imm_sel, opcode, dsel, a_sel, b_sel} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got we=%h mwe=%b wd=%h imm=%h isel=%b op=%h dsel=%b, expected all 0",
                  wen, mem_we, mem_wdata, imm, imm_sel, opcode, dsel);
      end
      nreset = 1'b1;
      pc_m = 16'h0000;
      flags_m = 5'h00;
   endtask

   task automatic test_directed();
      exec_one(16'h51FF, 5'h00, -1, 0);
      n_checks++;
      if (pc !== 16'h0001) begin
         n_errors++;
         $display("FAIL addi_pc: got %h expected 0001", pc);
      end
      exec_one(16'hF2AB, 5'h1F, -1, 0);
      regs[3] = 16'h1234;
      regs[4] = 16'h0040;
      exec_one(16'h4344, 5'h00, -1, 0);
      exec_one(16'h4504, 5'h00, -1, 0);
      regs[6] = 16'h000F;
      regs[7] = 16'h0000;
      exec_one(16'h4EC6, 5'h00, -1, 0);
      exec_one(16'h01B1, 5'b01000, -1, 0);
      exec_one(16'hC0FE, 5'h00, -1, 0);
      n_checks++;
      if (pc !== 16'h000E) begin
         n_errors++;
         $display("FAIL beq_taken: got %h expected 000E", pc);
      end
      exec_one(16'h4EC6, 5'h00, -1, 0);
      exec_one(16'h01B1, 5'b00000, -1, 0);
      exec_one(16'hC0FE, 5'h00, -1, 0);
      n_checks++;
      if (pc !== 16'h0011) begin
         n_errors++;
         $display("FAIL beq_not_taken: got %h expected 0011", pc);
      end
      exec_one(16'h4EC7, 5'h00, -1, 0);
      exec_one(16'hCEFF, 5'h00, -1, 0);
      n_checks++;
      if (pc !== 16'hFFFF) begin
         n_errors++;
         $display("FAIL branch_wrap: got %h expected FFFF", pc);
      end
      exec_one(16'h0000, 5'h00, -1, 0);
      n_checks++;
      if (pc !== 16'h0000) begin
         n_errors++;
         $display("FAIL pc_wrap: got %h expected 0000", pc);
      end
   endtask

   task automatic test_stall();
      exec_one(16'h0152, 5'h00, 2, 5);
   endtask

   task automatic test_reset_mid_load();
      int wrote = 0;
      regs[4] = 16'h0040;
      mem[pc_m] = 16'h4504;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      nreset = 1'b0;
      #1;
      if (wen !== 16'h0) wrote++;
      @(negedge clk);
      if (wen !== 16'h0) wrote++;
      n_checks++;
      if (wrote != 0 || dsel !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_load_wb: got %0d writes dsel=%b, expected 0 writes dsel=0", wrote, dsel);
      end
      n_checks++;
      if (pc !== 16'h0000 || mem_addr !== 16'h0000) begin
         n_errors++;
         $display("FAIL reset_load_pc: got pc=%h addr=%h, expected 0000", pc, mem_addr);
      end
      nreset = 1'b1;
      pc_m = 16'h0000;
      flags_m = 5'h00;
      exec_one(16'h0000, 5'h00, -1, 0);
   endtask

   function automatic logic [15:0] rand_instr();
      logic [3:0] fns [7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
      logic [3:0] iops [8] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};
      logic [3:0] r1 = 4'($urandom);
      logic [3:0] r2 = 4'($urandom);
      logic [7:0] b8 = 8'($urandom);
      case ($urandom_range(0, 9))
         0: return {4'h0, r1, fns[$urandom_range(0, 6)], r2};
         1: return {4'h0, r1, 4'($urandom), r2};
         2, 3: return {iops[$urandom_range(0, 7)], r1, b8};
         4: return {4'h4, r1, 4'h0, r2};
         5: return {4'h4, r1, 4'h4, r2};
         6: return {4'h4, r1, 4'hC, r2};
         7, 8: return {4'hC, r1, b8};
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic test_random();
      for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0)
            exec_one(rand_instr(), 5'($urandom), $urandom_range(0, 2), $urandom_range(1, 4));
         else
            exec_one(rand_instr(), 5'($urandom), -1, 0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_reset_mid_load();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
